// File: rtl/mix_columns_iter_if.sv
// rtl/mix_columns_iter_if.sv - start/result handshake bundle for the MixColumns unit
interface mix_columns_iter_if;
   logic         En_MXC;
   logic         Inv_MXC;
   logic [127:0] In_MXC;
   logic         Busy_MXC;
   logic         Ry_MXC;
   logic [127:0] Out_MXC;

   // round controller side
   modport master (
      output En_MXC, Inv_MXC, In_MXC,
      input  Busy_MXC, Ry_MXC, Out_MXC
   );

   // transform unit side
   modport slave (
      input  En_MXC, Inv_MXC, In_MXC,
      output Busy_MXC, Ry_MXC, Out_MXC
   );
endinterface

// File: rtl/mix_columns_iter.sv
// rtl/mix_columns_iter.sv - iterative AES MixColumns / InvMixColumns, COLS_PER_CYCLE columns per clock
module mix_columns_iter #(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic              Clk,
   input  logic              Rst,
   mix_columns_iter_if.slave mxc
);
   localparam int         N        = 4 / COLS_PER_CYCLE;
   localparam logic [1:0] LAST_GRP = 2'(N - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t       state_q, state_d;
   logic [1:0]   grp_q, grp_d;
   logic [127:0] in_q, in_d;
   logic         inv_q, inv_d;
   logic [127:0] acc_q, acc_d;
   logic [127:0] out_q, out_d;
   logic         ry_q, ry_d;

   logic         start;
   logic         active;
   logic         last;
   logic [1:0]   grp_cur;
   logic [127:0] src;
   logic         inv_src;
   logic [127:0] res;

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // constant multipliers used here all fit in 4 bits (01,02,03,09,0B,0D,0E)
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
      logic [7:0] x2, x4, x8;
      x2 = xt(a);
      x4 = xt(x2);
      x8 = xt(x4);
      return (m[0] ? a : 8'h00) ^ (m[1] ? x2 : 8'h00) ^ (m[2] ? x4 : 8'h00) ^ (m[3] ? x8 : 8'h00);
   endfunction

   // one column {row0,row1,row2,row3} through the circulant matrix
   function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
      logic [7:0]  a [4];
      logic [3:0]  m [4];
      logic [7:0]  o;
      logic [31:0] r;
      for (int i = 0; i < 4; i++) a[i] = col[31-8*i -: 8];
      if (inv) begin
         m[0] = 4'he; m[1] = 4'hb; m[2] = 4'hd; m[3] = 4'h9;
      end else begin
         m[0] = 4'h2; m[1] = 4'h3; m[2] = 4'h1; m[3] = 4'h1;
      end
      r = 32'h0;
      for (int row = 0; row < 4; row++) begin
         o = 8'h00;
         for (int k = 0; k < 4; k++) o = o ^ gmul(a[(row + k) & 3], m[k]);
         r[31-8*row -: 8] = o;
      end
      return r;
   endfunction

   // state register
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: if (start) state_d = (N == 1) ? DONE : RUN;
         RUN:        if (last)  state_d = DONE;
         default:    state_d = IDLE;
      endcase
   end

   // datapath: the accepting edge works on In_MXC directly, later edges on the latched copy
   always_comb begin
      logic [31:0] col;
      logic [31:0] mixed;
      int          c;
      start   = mxc.En_MXC && (state_q == IDLE || state_q == DONE);
      active  = start || (state_q == RUN);
      grp_cur = start ? 2'd0 : grp_q;
      last    = (grp_cur == LAST_GRP);
      src     = start ? mxc.In_MXC  : in_q;
      inv_src = start ? mxc.Inv_MXC : inv_q;
      res     = acc_q;
      for (int j = 0; j < COLS_PER_CYCLE; j++) begin
         c = int'(grp_cur) * COLS_PER_CYCLE + j;
         for (int r = 0; r < 4; r++) col[31-8*r -: 8] = src[127-8*(4*r+c) -: 8];
         mixed = mix_col(col, inv_src);
         for (int r = 0; r < 4; r++) res[127-8*(4*r+c) -: 8] = mixed[31-8*r -: 8];
      end
   end

   // output/register next values: Out_MXC only moves on the completing edge
   always_comb begin
      in_d  = start ? mxc.In_MXC  : in_q;
      inv_d = start ? mxc.Inv_MXC : inv_q;
      grp_d = active ? grp_cur + 2'd1 : grp_q;
      acc_d = active ? res : acc_q;
      out_d = (active && last) ? res : out_q;
      ry_d  = ry_q;
      if (start)          ry_d = 1'b0;
      if (active && last) ry_d = 1'b1;
      mxc.Busy_MXC = (state_q == RUN);
      mxc.Ry_MXC   = ry_q;
      mxc.Out_MXC  = out_q;
   end

   // datapath registers
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         grp_q <= 2'd0;
         in_q  <= 128'h0;
         inv_q <= 1'b0;
         acc_q <= 128'h0;
         out_q <= 128'h0;
         ry_q  <= 1'b0;
      end else begin
         grp_q <= grp_d;
         in_q  <= in_d;
         inv_q <= inv_d;
         acc_q <= acc_d;
         out_q <= out_d;
         ry_q  <= ry_d;
      end
   end
endmodule

// File: tb/tb_mix_columns_iter.sv
// tb/tb_mix_columns_iter.sv - directed check of mix_columns_iter at 1, 2 and 4 columns per cycle
module tb_mix_columns_iter;
   localparam logic [127:0] V2_IN  = 128'hd4e0b81ebfb441275d52119830aef1e5;
   localparam logic [127:0] V2_OUT = 128'h04e0482866cbf8068119d326e59a7a4c;
   localparam logic [127:0] V3_IN  = 128'h49457f77db3902de8753d2963b89f11a;
   localparam logic [127:0] V3_OUT = 128'h581bdb1b4d4be76bca5acab0f1aca8e5;

   logic         Clk;
   logic         Rst;
   logic [2:0]   en;
   logic         inv;
   logic [127:0] din;
   logic [2:0]   ry, busy;
   logic [127:0] outv [3];
   logic [127:0] prev [3];
   int           nl [3];
   int           n_assert;
   int           n_fail;

   mix_columns_iter_if if0 ();
   mix_columns_iter_if if1 ();
   mix_columns_iter_if if2 ();

   assign if0.En_MXC = en[0];  assign if0.Inv_MXC = inv;  assign if0.In_MXC = din;
   assign if1.En_MXC = en[1];  assign if1.Inv_MXC = inv;  assign if1.In_MXC = din;
   assign if2.En_MXC = en[2];  assign if2.Inv_MXC = inv;  assign if2.In_MXC = din;

   assign ry[0] = if0.Ry_MXC;  assign busy[0] = if0.Busy_MXC;  assign outv[0] = if0.Out_MXC;
   assign ry[1] = if1.Ry_MXC;  assign busy[1] = if1.Busy_MXC;  assign outv[1] = if1.Out_MXC;
   assign ry[2] = if2.Ry_MXC;  assign busy[2] = if2.Busy_MXC;  assign outv[2] = if2.Out_MXC;

   mix_columns_iter #(.COLS_PER_CYCLE(1)) u_dut1 (.Clk(Clk), .Rst(Rst), .mxc(if0));
   mix_columns_iter #(.COLS_PER_CYCLE(2)) u_dut2 (.Clk(Clk), .Rst(Rst), .mxc(if1));
   mix_columns_iter #(.COLS_PER_CYCLE(4)) u_dut4 (.Clk(Clk), .Rst(Rst), .mxc(if2));

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input int d, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
      end
   endtask

   task automatic chk_all_reset(input string tag);
      for (int d = 0; d < 3; d++) begin
         chk({tag, "_ry"},   d, 128'(ry[d]),   128'h0);
         chk({tag, "_busy"}, d, 128'(busy[d]), 128'h0);
         chk({tag, "_out"},  d, outv[d],       128'h0);
      end
   endtask

   // start all three units together, then check each at its own latency N
   task automatic run_vec(input string tag, input logic v_inv, input logic [127:0] v_in,
                          input logic [127:0] v_exp, input logic scramble);
      @(negedge Clk);
      inv = v_inv;
      din = v_in;
      en  = 3'b111;
      for (int k = 1; k <= 4; k++) begin
         @(negedge Clk);
         if (k == 1) begin
            en = 3'b000;
            if (scramble) begin
               din = ~v_in ^ 128'h5a5a_0f0f_3c3c_9696_a5a5_f0f0_c3c3_6969;
               inv = ~v_inv;
               en  = 3'b011;
            end
         end
         if (k == 2) en = 3'b000;
         for (int d = 0; d < 3; d++) begin
            if (k < nl[d]) begin
               chk({tag, "_busy_run"}, d, 128'(busy[d]), 128'h1);
               chk({tag, "_ry_run"},   d, 128'(ry[d]),   128'h0);
               chk({tag, "_out_hold"}, d, outv[d],       prev[d]);
            end else begin
               chk({tag, "_busy_done"}, d, 128'(busy[d]), 128'h0);
               chk({tag, "_ry_done"},   d, 128'(ry[d]),   128'h1);
               chk({tag, "_out"},       d, outv[d],       v_exp);
            end
         end
      end
      for (int d = 0; d < 3; d++) prev[d] = v_exp;
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      nl[0] = 4; nl[1] = 2; nl[2] = 1;
      Clk = 1'b0;
      Rst = 1'b0;
      en  = 3'b000;
      inv = 1'b0;
      din = 128'h0;
      for (int d = 0; d < 3; d++) prev[d] = 128'h0;

      #1 Rst = 1'b1;
      #1 chk_all_reset("reset_async");
      @(negedge Clk);
      Rst = 1'b0;

      run_vec("fwd_v2", 1'b0, V2_IN, V2_OUT, 1'b0);
      run_vec("fwd_v3", 1'b0, V3_IN, V3_OUT, 1'b0);
      run_vec("inv_v4", 1'b1, V2_OUT, V2_IN, 1'b0);
      run_vec("scramble_v2", 1'b0, V2_IN, V2_OUT, 1'b1);

      @(negedge Clk);
      inv = 1'b0;
      din = V3_IN;
      en  = 3'b111;
      @(negedge Clk);
      en  = 3'b000;
      chk("midrun_busy", 0, 128'(busy[0]), 128'h1);
      chk("midrun_busy", 1, 128'(busy[1]), 128'h1);
      Rst = 1'b1;
      #1 chk_all_reset("reset_midrun");
      @(negedge Clk);
      chk_all_reset("reset_held");
      Rst = 1'b0;
      for (int d = 0; d < 3; d++) prev[d] = 128'h0;
      run_vec("after_reset_v4", 1'b1, V2_OUT, V2_IN, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
